// File: rtl/muldiv_iter_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op_i codes and FSM states.
package muldiv_iter_pkg;

    localparam logic [1:0] MULDIV_MULTU = 2'b00;
    localparam logic [1:0] MULDIV_MULT  = 2'b01;
    localparam logic [1:0] MULDIV_DIVU  = 2'b10;
    localparam logic [1:0] MULDIV_DIV   = 2'b11;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StDivZero = 2'd1,
        StBusy    = 2'd2,
        StDone    = 2'd3
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate, used for operand magnitude and result sign fix-up.
module muldiv_negate #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             neg_i,
    input  logic [WIDTH-1:0] a_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = neg_i ? (~a_i + WIDTH'(1)) : a_i;

endmodule

// File: rtl/muldiv_iter.sv
// Iterative one-bit-per-cycle MULT/MULTU/DIV/DIVU unit producing a {HI, LO} pair.
module muldiv_iter
    import muldiv_iter_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [1:0]         op_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic               stallreq_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned AW    = 2 * WIDTH + 1;

    muldiv_state_e state_q, state_d;

    logic               div_q, div_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   addend_q, addend_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic               op_signed, op_div, s1, s2, accept, cnt_last;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     mul_sum, div_diff;
    logic [AW-1:0]      mul_step, div_sh, div_step, acc_step;
    logic [2*WIDTH-1:0] prod_fix, final_res;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign op_signed = op_i[0];
    assign op_div    = op_i[1];
    assign s1        = op_signed & opdata1_i[WIDTH-1];
    assign s2        = op_signed & opdata2_i[WIDTH-1];
    assign accept    = start_i & ~annul_i;
    assign cnt_last  = (cnt_q == CNT_W'(WIDTH - 1));

    muldiv_negate #(.WIDTH(WIDTH)) u_neg_op1 (.neg_i(s1), .a_i(opdata1_i), .y_o(mag1));
    muldiv_negate #(.WIDTH(WIDTH)) u_neg_op2 (.neg_i(s2), .a_i(opdata2_i), .y_o(mag2));

    // Multiply: acc = {carry, hi, lo}; lo starts as the multiplier and shifts out LSB-first.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, addend_q} : '0);
    assign mul_step = {1'b0, mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: shift {rem, quo} left, keep the subtraction only if it did not borrow.
    assign div_sh   = {acc_q[2*WIDTH-1:0], 1'b0};
    assign div_diff = div_sh[AW-1:WIDTH] - {1'b0, addend_q};
    assign div_step = div_diff[WIDTH] ? div_sh : {div_diff, div_sh[WIDTH-1:1], 1'b1};

    assign acc_step = div_q ? div_step : mul_step;

    muldiv_negate #(.WIDTH(2 * WIDTH)) u_neg_prod (
        .neg_i(neg_quo_q),
        .a_i  (acc_step[2*WIDTH-1:0]),
        .y_o  (prod_fix)
    );
    muldiv_negate #(.WIDTH(WIDTH)) u_neg_quo (
        .neg_i(neg_quo_q),
        .a_i  (acc_step[WIDTH-1:0]),
        .y_o  (quo_fix)
    );
    muldiv_negate #(.WIDTH(WIDTH)) u_neg_rem (
        .neg_i(neg_rem_q),
        .a_i  (acc_step[2*WIDTH-1:WIDTH]),
        .y_o  (rem_fix)
    );

    assign final_res = div_q ? {rem_fix, quo_fix} : prod_fix;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (op_div && opdata2_i == '0) ? StDivZero : StBusy;
                end
            end
            StDivZero: state_d = annul_i ? StIdle : StDone;
            StBusy: begin
                if (annul_i) begin
                    state_d = StIdle;
                end else if (cnt_last) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = (annul_i || !start_i) ? StIdle : StDone;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ready_o = (state_q == StDone);
        busy_o  = (state_q != StIdle);
    end

    assign stallreq_o = start_i & ~ready_o;
    assign result_o   = result_q;

    always_comb begin
        div_d     = div_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        addend_d  = addend_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    div_d     = op_div;
                    neg_quo_d = s1 ^ s2;
                    neg_rem_d = s1;
                    cnt_d     = '0;
                    if (op_div) begin
                        addend_d = mag2;
                        // Divide-by-zero parks the raw dividend/all-ones result in acc.
                        acc_d    = (opdata2_i == '0) ? {1'b0, opdata1_i, {WIDTH{1'b1}}}
                                                     : {1'b0, {WIDTH{1'b0}}, mag1};
                    end else begin
                        addend_d = mag1;
                        acc_d    = {1'b0, {WIDTH{1'b0}}, mag2};
                    end
                end
            end
            StDivZero: begin
                if (!annul_i) begin
                    result_d = acc_q[2*WIDTH-1:0];
                end
            end
            StBusy: begin
                if (!annul_i) begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_last) begin
                        result_d = final_res;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q     <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            addend_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            div_q     <= div_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            addend_q  <= addend_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
        end
    end

endmodule
